// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to add the fetch starvation guard (otherwise data strictly wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int LW = $clog2(MEM_LAT + 1);
  state_t state, state_nx;
  logic [LW-1:0] lat;
  logic own_d;
  logic grant_d;
  logic arb;
  assign arb = (state == IDLE) & (if_req | d_req);
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  // Fetch overrides data only once it has watched STARVE_MAX data grants in a row.
  assign grant_d = d_req & ~(if_req & (starve == SW'(STARVE_MAX)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) starve <= '0;
    else if (state == IDLE)
      starve <= !if_req ? '0 : !grant_d ? '0 : (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
`else
  assign grant_d = d_req;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (arb ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (lat == LW'(1) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lat       <= '0;
      own_d     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (arb) begin
        own_d    <= grant_d;
        mem_addr <= grant_d ? d_addr : if_addr;
        mem_we   <= grant_d & d_we;
        if (grant_d) mem_wdata <= d_wdata;
      end
      if (state == ISSUE) lat <= LW'(MEM_LAT);
      else if (state == WAIT) lat <= lat - 1'b1;
      if (state == WAIT && lat == LW'(1)) begin
        if (!own_d) if_rdata <= mem_rdata[31:0];
        else if (!mem_we) d_rdata <= mem_rdata;
      end
    end
  assign mem_en    = state == ISSUE;
  assign busy      = state != IDLE;
  assign if_valid  = (state == DONE) & ~own_d;
  assign d_valid   = (state == DONE) & own_d;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a
// transaction-timestamp reference model; honours ARB_STARVE_GUARD_EN like the design.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 64, DW = 64, L = 2, SM = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 0, reset = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [31:0] if_rdata;
  logic if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem, busy;
  logic [DW-1:0] d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  int total = 0, bad = 0, cyc = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] salt(logic [63:0] a);
    return {a[31:0] * 32'h9E3779B1, ~a[31:0]};
  endfunction
  function automatic int idx(logic [63:0] a);
    return int'(a[9:2]);
  endfunction

  // Memory macro: fixed latency L from the edge sampling mem_en; garbage on idle cycles.
  bit [63:0] mem [256];
  logic [63:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mem_en ? (mem[idx(mem_addr)] ^ salt(mem_addr)) : {$urandom, $urandom};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) mem[idx(mem_addr)] <= mem_wdata ^ salt(mem_addr);
  end
  assign mem_rdata = pipe[L-1];

  bit [63:0] ref_mem [256];
  function automatic logic [63:0] ref_rd(logic [63:0] a);
    return ref_mem[idx(a)] ^ salt(a);
  endfunction

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Reference: an access granted in cycle t0 strobes at t0+1, completes at t0+L+2,
  // and the next grant can happen at t0+L+3.
  bit act, own_d, t_we, saw_i, saw_d, en_we;
  int t0, starve, en_cnt, en_at;
  logic [63:0] t_addr, t_wdata, e_addr, e_drd, en_addr, en_wdata;
  logic [31:0] e_ird;
  always @(negedge clk) begin : model
    bit e_en, e_iv, e_dv, e_busy, idle, gd;
    logic [63:0] v;
    if (!reset) begin
      act = 0; starve = 0; e_addr = '0; e_ird = '0; e_drd = '0;
      e_en = 0; e_iv = 0; e_dv = 0; e_busy = 0;
    end else begin
      e_en   = act && cyc == t0 + 1;
      e_busy = act && cyc > t0 && cyc <= t0 + L + 2;
      e_iv   = act && !own_d && cyc == t0 + L + 2;
      e_dv   = act && own_d && cyc == t0 + L + 2;
      v = ref_rd(t_addr);
      if (e_iv) e_ird = v[31:0];
      if (e_dv && !t_we) e_drd = v;
    end
    chk("busy", busy, e_busy);
    chk("mem_en", mem_en, e_en);
    chk("if_valid", if_valid, e_iv);
    chk("d_valid", d_valid, e_dv);
    chk("stall_if", stall_if, if_req & !e_iv);
    chk("stall_mem", stall_mem, d_req & !e_dv);
    chk("if_rdata", if_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("mem_addr", mem_addr, e_addr);
    if (!reset) begin
      chk("mem_we_rst", mem_we, 0);
      chk("mem_wdata_rst", mem_wdata, 0);
    end else if (e_en) begin
      chk("mem_we", mem_we, t_we);
      if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
    end
    saw_i = if_valid;
    saw_d = d_valid;
    if (mem_en) begin
      en_cnt++; en_at = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
    end
    idle = reset && (!act || cyc >= t0 + L + 3);
    if (idle) begin
      gd = d_req && !(GUARD && if_req && starve == SM);
      if (if_req || d_req) begin
        act = 1; t0 = cyc; own_d = gd; t_we = gd && d_we;
        t_addr = gd ? d_addr : if_addr; t_wdata = d_wdata; e_addr = t_addr;
        if (t_we) ref_mem[idx(d_addr)] = d_wdata ^ salt(d_addr);
      end
      starve = !if_req ? 0 : gd ? (starve < SM ? starve + 1 : starve) : 0;
    end
  end

  // Requesters drop their request the cycle after seeing their valid pulse.
  task automatic step();
    @(posedge clk); #1;
    if (saw_i) if_req = 0;
    if (saw_d) d_req = 0;
  endtask

  task automatic run_d(input bit we, input logic [63:0] a, input logic [63:0] wd, output int lat);
    int s;
    step(); d_req = 1; d_we = we; d_addr = a; d_wdata = wd; s = cyc; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin step(); if (saw_d) lat = cyc - 1 - s; end
    step();
  endtask

  task automatic run_i(input logic [63:0] a, output int s, output int lat);
    step(); if_req = 1; if_addr = a; s = cyc; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin step(); if (saw_i) lat = cyc - 1 - s; end
    step();
  endtask

  initial begin
    int lat, s, n, ti, td, gi, ng, r;
    repeat (2) begin
      step();
      if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      if_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
    end
    step(); if_req = 0; d_req = 0; #2 reset = 1;
    run_d(1, 64'h10, 64'h0050_0093, lat);
    chk("st_lat", lat, 4);
    run_d(1, 64'h30, 64'h55, lat);
    run_d(0, 64'h30, 64'h0, lat);
    chk("ld_lat", lat, 4);
    chk("ld_rdata", d_rdata, 64'h55);
    n = en_cnt;
    run_d(1, 64'h20, 64'hAB, lat);
    chk("st2_lat", lat, 4);
    chk("st2_en_cnt", en_cnt - n, 1);
    chk("st2_we", en_we, 1);
    chk("st2_wdata", en_wdata, 64'hAB);
    chk("st2_keep_rdata", d_rdata, 64'h55);
    chk("st2_mem", mem[idx(64'h20)] ^ salt(64'h20), 64'hAB);
    n = en_cnt;
    run_i(64'h10, s, lat);
    chk("if_lat", lat, 4);
    chk("if_en_cnt", en_cnt - n, 1);
    chk("if_en_at", en_at - s, 1);
    chk("if_en_addr", en_addr, 64'h10);
    chk("if_en_we", en_we, 0);
    chk("if_rdata_lit", if_rdata, 32'h0050_0093);
    step(); if_req = 1; if_addr = 64'h14; d_req = 1; d_we = 0; d_addr = 64'h100; s = cyc; ti = -1; td = -1;
    for (int k = 0; k < 40 && ti < 0; k++) begin
      step();
      if (saw_d && td < 0) td = cyc - 1 - s;
      if (saw_i && ti < 0) ti = cyc - 1 - s;
    end
    chk("both_d_lat", td, 4);
    chk("both_i_lat", ti, 9);
    chk("both_i_en_at", en_at - s, 6);
    chk("both_i_en_addr", en_addr, 64'h14);
    step();
    step(); if_req = 1; if_addr = 64'h40; gi = 0; ng = 0; n = en_cnt;
    for (int k = 0; k < 80 && gi == 0 && ng < 10; k++) begin
      d_req = 1; d_we = 0; d_addr = 64'h80;
      step();
      d_req = 1;
      if (en_cnt != n) begin n = en_cnt; ng++; if (en_addr == 64'h40) gi = ng; end
    end
    chk("starve_fetch_grant", gi, GUARD ? 5 : 0);
    d_req = 0;
    for (int k = 0; k < 40 && if_req; k++) step();
    step();
    step(); d_req = 1; d_we = 0; d_addr = 64'h30;
    step(); step();
    #2 reset = 0; #1;
    chk("rstw_mem_en", mem_en, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_d_valid", d_valid, 0);
    chk("rstw_d_rdata", d_rdata, 0);
    step(); step();
    #2 reset = 1; r = cyc; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin step(); if (saw_d) lat = cyc - 1 - r; end
    chk("rstw_reissue_lat", lat, 4);
    chk("rstw_reissue_en", en_at - r, 1);
    chk("rstw_reissue_rdata", d_rdata, 64'h55);
    for (int k = 0; k < 1200; k++) begin
      step();
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 64'($urandom_range(0, 255)) << 2;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 64'($urandom_range(0, 255)) << 2; d_wdata = {$urandom, $urandom};
      end
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 0;
        repeat ($urandom_range(1, 3)) step();
        #2 reset = 1;
      end
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
